stopwatch_display: RTL and testbench



---
 rtl/stopwatch_disp_pkg.sv | 45 ++++
 rtl/sec_to_bcd.sv | 101 ++++++++++
 rtl/stopwatch_display.sv | 126 ++++++++++++
 tb/tb_stopwatch_display.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_disp_pkg.sv
// Shared types and constants for the stopwatch MM:SS display back-end:
// converter FSM states, saturation limit and 7-segment codes.
package stopwatch_disp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV60,
    BCD_MIN,
    BCD_SEC,
    COMMIT
  } conv_state_e;

  localparam logic [12:0] MAX_SECONDS = 13'd5999;
  localparam logic [6:0]  SEG_BLANK   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode digit.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/sec_to_bcd.sv
// Sequential seconds -> MM:SS BCD converter: repeated subtract-60 for minutes,
// then subtract-10 for each field's tens digit. One step per clock.
module sec_to_bcd
  import stopwatch_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] value,
  output logic        busy,
  output logic        done,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones
);

  conv_state_e state, state_next;
  logic [12:0] value_q;
  logic [12:0] rem;
  logic [6:0]  m;
  logic        accept;

  // A new request is taken in IDLE, or in COMMIT to chain straight into LOAD.
  assign accept = start && ((state == IDLE) || (state == COMMIT));

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD:    state_next = DIV60;
      DIV60:   if (rem < 13'd60) state_next = BCD_MIN;
      BCD_MIN: if (m < 7'd10)    state_next = BCD_SEC;
      BCD_SEC: if (rem < 13'd10) state_next = COMMIT;
      COMMIT: begin
        done       = 1'b1;
        state_next = start ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: datapath is reset too, so an aborted conversion leaves no stale digits behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      rem      <= '0;
      m        <= '0;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      if (accept) value_q <= value;
      case (state)
        LOAD: begin
          rem      <= (value_q > MAX_SECONDS) ? MAX_SECONDS : value_q;
          m        <= '0;
          min_tens <= '0;
          sec_tens <= '0;
        end
        DIV60: begin
          if (rem >= 13'd60) begin
            rem <= rem - 13'd60;
            m   <= m + 7'd1;
          end
        end
        BCD_MIN: begin
          if (m >= 7'd10) begin
            m        <= m - 7'd10;
            min_tens <= min_tens + 4'd1;
          end else begin
            min_ones <= m[3:0];
          end
        end
        BCD_SEC: begin
          if (rem >= 13'd10) begin
            rem      <= rem - 13'd10;
            sec_tens <= sec_tens + 4'd1;
          end else begin
            sec_ones <= rem[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch display: request buffering, BCD conversion, digit scan and decode.
// Optional adjust-mode field blinking is built when STOPWATCH_DISP_BLINK_EN is defined.
module stopwatch_display
  import stopwatch_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 262144,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] seconds,
  input  logic        update,
  input  logic        adj,
  input  logic        sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic        pending;
  logic [12:0] shadow;
  logic        start;
  logic [12:0] conv_value;
  logic        conv_done;
  logic [15:0] conv_bcd;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [15:0] disp_bcd;

  // A buffered request always takes priority over a fresh strobe.
  assign start      = pending || (update && !busy);
  assign conv_value = pending ? shadow : seconds;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      shadow  <= '0;
    end else if (update && busy) begin
      pending <= 1'b1;
      shadow  <= seconds;
    end else if (pending && (!busy || conv_done)) begin
      pending <= 1'b0;
    end
  end

  sec_to_bcd u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (conv_value),
    .busy     (busy),
    .done     (conv_done),
    .min_tens (conv_bcd[15:12]),
    .min_ones (conv_bcd[11:8]),
    .sec_tens (conv_bcd[7:4]),
    .sec_ones (conv_bcd[3:0])
  );

  // All four digits swap together, so a half-converted value is never shown.
  always_ff @(posedge clk) begin
    if (rst)            disp_bcd <= '0;
    else if (conv_done) disp_bcd <= conv_bcd;
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [3:0]        cur_digit;
  logic              field_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign cur_digit = disp_bcd[{idx, 2'b00} +: 4];

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  // Held cleared outside adjust mode, so each adjust session starts visible.
  always_ff @(posedge clk) begin
    if (rst || !adj) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // idx[1] = 1 selects the minutes pair; sel = 1 selects seconds.
  assign field_blank = adj && phase && (idx[1] == ~sel);
`else
  logic unused_adjust;
  assign unused_adjust = adj ^ sel;
  assign field_blank   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= field_blank ? SEG_BLANK : seg_decode(cur_digit);
      an  <= ~(4'b0001 << idx);
      dp  <= (idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: directed updates push expected commits,
// a monitor checks each commit; scan outputs are checked against a segment table.
module tb_stopwatch_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] seconds;
  logic        update;
  logic        adj;
  logic        sel;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;

  stopwatch_display #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seconds (seconds),
    .update  (update),
    .adj     (adj),
    .sel     (sel),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] bcd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int an_slot(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Commit monitor: every converter commit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && dut.u_conv.done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_commit: got %h at cycle %0d, required no commit", dut.conv_bcd, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("commit_cycle", cyc, mon_e.cyc);
        check("commit_digits", dut.conv_bcd, mon_e.bcd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [12:0] s);
    seconds = s;
    update  = 1'b1;
    tick(1);
    update  = 1'b0;
  endtask

  task automatic expect_commit(input logic [15:0] bcd, input int at_cycle);
    exp_t e;
    e.bcd = bcd;
    e.cyc = at_cycle;
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, (k < budget), 1);
    tick(2);
  endtask

  task automatic check_display(input string name, input logic [15:0] bcd);
    logic [3:0] seen;
    int         slot;
    seen = 4'h0;
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      slot = an_slot(an);
      if (slot < 0) begin
        check({name, "_an"}, an, 4'hE);
      end else begin
        seen[slot] = 1'b1;
        check({name, "_seg"}, seg, SEG_TAB[bcd[slot*4 +: 4]]);
        check({name, "_dp"}, dp, (slot == 2) ? 1'b0 : 1'b1);
      end
    end
    check({name, "_slots"}, seen, 4'hF);
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int         c0;
    int         nb;
    logic [3:0] an_exp;
    int         idx;
    rst     = 1'b1;
    update  = 1'b0;
    seconds = '0;
    adj     = 1'b0;
    sel     = 1'b0;
    tick(3);

    @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Free-running scan from reset: one slot per SCAN_DIV cycles.
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      idx    = k / SCAN_DIV;
      an_exp = ~(4'b0001 << idx);
      check("scan_an", an, an_exp);
      check("scan_seg", seg, 7'h40);
      check("scan_dp", dp, (idx == 2) ? 1'b0 : 1'b1);
    end
    tick(1);

    // v = 0: minimum latency 5.
    expect_commit(16'h0000, cyc + 5);
    issue(13'd0);
    drain("drain_zero", 50);

    // 754 s = 12:34, latency 1+13+2+4+1 = 21; busy over the same 21 cycles.
    expect_commit(16'h1234, cyc + 21);
    issue(13'd754);
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (busy) nb++;
      else break;
    end
    check("busy_cycles_754", nb, 21);
    tick(1);
    drain("drain_754", 50);
    check_display("disp_1234", 16'h1234);

    // 59 s = 00:59 (latency 1+1+1+6+1 = 10); 600 s = 10:00 (1+11+2+1+1 = 16).
    expect_commit(16'h0059, cyc + 10);
    issue(13'd59);
    drain("drain_59", 50);
    check_display("disp_0059", 16'h0059);
    expect_commit(16'h1000, cyc + 16);
    issue(13'd600);
    drain("drain_600", 50);
    check_display("disp_1000", 16'h1000);

    // Saturation: 6039 shows 99:59 with the maximum latency of 118.
    expect_commit(16'h9959, cyc + 118);
    issue(13'd6039);
    drain("drain_6039", 200);
    check_display("disp_9959", 16'h9959);

    // Strobes while busy: last buffered value (61) follows 754; 5 is overwritten.
    c0 = cyc;
    expect_commit(16'h1234, c0 + 21);
    expect_commit(16'h0101, c0 + 21 + 6);
    issue(13'd754);
    while (cyc < c0 + 3) tick(1);
    issue(13'd5);
    while (cyc < c0 + 10) tick(1);
    issue(13'd61);
    drain("drain_chain", 100);
    check_display("disp_0101", 16'h0101);

    // Reset mid-conversion: aborts, zeros digits, nothing commits afterwards.
    c0 = cyc;
    issue(13'd5999);
    while (cyc < c0 + 8) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 1'b0);
    tick(1);
    check_display("disp_rst_mid", 16'h0000);
    tick(150);
    check("rst_mid_sb_empty", sb.size(), 0);

`ifdef STOPWATCH_DISP_BLINK_EN
    begin
      int nblank;
      int nshow;
      int slot;
      int k;
      k = 0;
      while (an != 4'b0111 && k < 64) begin @(negedge clk); k++; end
      while (an != 4'b1110 && k < 64) begin @(negedge clk); k++; end
      check("blink_align", (k < 64), 1);
      tick(2);
      adj    = 1'b1;
      sel    = 1'b1;
      nblank = 0;
      nshow  = 0;
      for (int j = 0; j < 64; j++) begin
        @(negedge clk);
        slot = an_slot(an);
        if (slot >= 2) begin
          check("blink_min_shown", seg, SEG_TAB[0]);
        end else if (seg == 7'h7F) begin
          nblank++;
        end else begin
          nshow++;
          check("blink_sec_shown", seg, SEG_TAB[0]);
        end
      end
      check("blink_sec_blanked", (nblank > 0), 1);
      check("blink_sec_visible", (nshow > 0), 1);
      tick(1);
      adj = 1'b0;
    end
`endif

    tick(2);
    check("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
